// File: rtl/dump_pkg.sv
// Shared widths, state encodings and byte-count constants for the state-dump sequencer.
package dump_pkg;

  localparam int unsigned BYTE           = 8;
  localparam int unsigned DWORD          = 32;
  localparam int unsigned RB_ADDR        = 5;
  localparam int unsigned DM_ADDR        = 5;
  localparam int unsigned NB_RB_WORDS    = 32;
  localparam int unsigned NB_DM_WORDS    = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned TOTAL_BYTES    = BYTES_PER_WORD * (1 + NB_RB_WORDS + NB_DM_WORDS);
  localparam int unsigned IDX_W          = 6;
  localparam int unsigned BCNT_W         = 2;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, RB_REQ, RB_CAP, DM_REQ, DM_CAP, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_PC, PH_RB, PH_DM
  } phase_t;

  typedef enum logic [1:0] {
    SER_IDLE, SER_SEND, SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/word_tx_serializer.sv
// Holds one 32-bit word and hands it to the UART byte by byte, LSB first,
// using a one-cycle start pulse and a done handshake per byte.
module word_tx_serializer
  import dump_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [DWORD-1:0] i_word,
  input  logic             i_tx_done,
  output logic [BYTE-1:0]  o_tx_data,
  output logic             o_tx_start,
  output logic             o_byte_done_c,
  output logic             o_word_done_c
);

  ser_state_t        r_state, w_next_state;
  logic [BCNT_W-1:0] r_byte_cnt, w_next_cnt;
  logic [DWORD-1:0]  r_word, w_next_word;
  logic [BYTE-1:0]   r_tx_data;
  logic              r_tx_start;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= SER_IDLE;
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_byte_cnt <= w_next_cnt;
      r_word     <= w_next_word;
    end
  end

  // tx_done only matters while waiting, so a stray done never skips a byte
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_byte_cnt;
    w_next_word   = r_word;
    o_byte_done_c = 1'b0;
    o_word_done_c = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (i_load) begin
          w_next_state = SER_SEND;
          w_next_cnt   = '0;
          w_next_word  = i_word;
        end
      end
      SER_SEND: w_next_state = SER_WAIT;
      SER_WAIT: begin
        if (i_tx_done) begin
          o_byte_done_c = 1'b1;
          if (r_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1)) begin
            o_word_done_c = 1'b1;
            w_next_cnt    = '0;
            w_next_state  = SER_IDLE;
          end else begin
            w_next_cnt   = r_byte_cnt + BCNT_W'(1);
            w_next_state = SER_SEND;
          end
        end
      end
      default: w_next_state = SER_IDLE;
    endcase
  end

  // Byte lane is chosen from next-state values so data and start line up
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= (w_next_state == SER_SEND);
      if (w_next_state == SER_SEND)
        r_tx_data <= w_next_word[{w_next_cnt, 3'b000} +: BYTE];
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule

// File: rtl/dump_sequencer.sv
// Walks PC, register bank and data memory after halt/step, fetching each word
// through the debug read ports and streaming it to the UART transmitter.
module dump_sequencer
  import dump_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [DWORD-1:0]   i_pc_value,
  input  logic [DWORD-1:0]   i_rb_data,
  input  logic [DWORD-1:0]   i_dm_data,
  input  logic               i_tx_done,
  output logic [RB_ADDR-1:0] o_rb_addr,
  output logic               o_rb_enable,
  output logic               o_rb_read_enable,
  output logic [DM_ADDR-1:0] o_dm_addr,
  output logic               o_dm_enable,
  output logic               o_dm_read_enable,
  output logic               o_dm_du_flag,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  state_t            r_state, w_next_state;
  phase_t            r_phase, w_next_phase;
  logic [IDX_W-1:0]  r_idx, w_next_idx;
  logic              w_load;
  logic [DWORD-1:0]  w_load_word;
  logic              w_byte_done;
  logic              w_word_done;

  logic [RB_ADDR-1:0] r_rb_addr;
  logic [DM_ADDR-1:0] r_dm_addr;
  logic               r_rb_en, r_dm_en, r_busy, r_done;

  word_tx_serializer u_ser (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_load        (w_load),
    .i_word        (w_load_word),
    .i_tx_done     (i_tx_done),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_byte_done_c (w_byte_done),
    .o_word_done_c (w_word_done)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_phase <= PH_PC;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_next_idx   = r_idx;
    w_load       = 1'b0;
    w_load_word  = i_pc_value;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = SEND;
          w_next_phase = PH_PC;
          w_next_idx   = '0;
          w_load       = 1'b1;
        end
      end
      SEND: w_next_state = WAIT;
      WAIT: begin
        if (w_word_done) begin
          case (r_phase)
            PH_PC: begin
              w_next_state = RB_REQ;
              w_next_phase = PH_RB;
              w_next_idx   = '0;
            end
            PH_RB: begin
              if (r_idx != IDX_W'(NB_RB_WORDS - 1)) begin
                w_next_state = RB_REQ;
                w_next_idx   = r_idx + IDX_W'(1);
              end else begin
                w_next_state = DM_REQ;
                w_next_phase = PH_DM;
                w_next_idx   = '0;
              end
            end
            PH_DM: begin
              if (r_idx != IDX_W'(NB_DM_WORDS - 1)) begin
                w_next_state = DM_REQ;
                w_next_idx   = r_idx + IDX_W'(1);
              end else begin
                w_next_state = DONE;
              end
            end
            default: w_next_state = DONE;
          endcase
        end else if (w_byte_done) begin
          w_next_state = SEND;
        end
      end
      RB_REQ: w_next_state = RB_CAP;
      RB_CAP: begin
        w_load       = 1'b1;
        w_load_word  = i_rb_data;
        w_next_state = SEND;
      end
      DM_REQ: w_next_state = DM_CAP;
      DM_CAP: begin
        w_load       = 1'b1;
        w_load_word  = i_dm_data;
        w_next_state = SEND;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs follow the state they belong to, registered from the next state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rb_addr <= '0;
      r_dm_addr <= '0;
      r_rb_en   <= 1'b0;
      r_dm_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rb_en <= (w_next_state == RB_REQ);
      r_dm_en <= (w_next_state == DM_REQ);
      r_busy  <= (w_next_state != IDLE);
      r_done  <= (w_next_state == DONE);
      if (w_next_state == RB_REQ) r_rb_addr <= RB_ADDR'(w_next_idx);
      if (w_next_state == DM_REQ) r_dm_addr <= DM_ADDR'(w_next_idx);
    end
  end

  assign o_rb_addr        = r_rb_addr;
  assign o_rb_enable      = r_rb_en;
  assign o_rb_read_enable = r_rb_en;
  assign o_dm_addr        = r_dm_addr;
  assign o_dm_enable      = r_dm_en;
  assign o_dm_read_enable = r_dm_en;
  assign o_dm_du_flag     = r_busy;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: expected bytes and read addresses are
// queued at stimulus time and checked by a monitor as the DUT produces them.
module tb_dump_sequencer;
  import dump_pkg::*;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic [DWORD-1:0]   i_pc_value;
  logic [DWORD-1:0]   i_rb_data = '0;
  logic [DWORD-1:0]   i_dm_data = '0;
  logic               i_tx_done;
  logic [RB_ADDR-1:0] o_rb_addr;
  logic               o_rb_enable, o_rb_read_enable;
  logic [DM_ADDR-1:0] o_dm_addr;
  logic               o_dm_enable, o_dm_read_enable, o_dm_du_flag;
  logic [BYTE-1:0]    o_tx_data;
  logic               o_tx_start, o_busy, o_done;

  logic model_done = 1'b0;
  logic spurious_done = 1'b0;
  int   tx_timer = 0;
  assign i_tx_done = model_done | spurious_done;

  dump_sequencer dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_pc_value       (i_pc_value),
    .i_rb_data        (i_rb_data),
    .i_dm_data        (i_dm_data),
    .i_tx_done        (i_tx_done),
    .o_rb_addr        (o_rb_addr),
    .o_rb_enable      (o_rb_enable),
    .o_rb_read_enable (o_rb_read_enable),
    .o_dm_addr        (o_dm_addr),
    .o_dm_enable      (o_dm_enable),
    .o_dm_read_enable (o_dm_read_enable),
    .o_dm_du_flag     (o_dm_du_flag),
    .o_tx_data        (o_tx_data),
    .o_tx_start       (o_tx_start),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tx_count = 0;
  int done_count = 0;
  int rb_strobes = 0;
  int dm_strobes = 0;
  int strobe_cyc = 0;
  bit strobe_pending = 1'b0;
  logic [7:0] byte_log [0:299];
  logic [7:0] exp_bytes [$];
  logic [6:0] exp_addr [$];

  function automatic logic [31:0] rb_val(input int k);
    return 32'h01010101 * 32'(k);
  endfunction

  function automatic logic [31:0] dm_val(input int k);
    return 32'hA5000000 + 32'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memories: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (o_rb_read_enable) i_rb_data <= rb_val(int'(o_rb_addr));
    if (o_dm_read_enable) i_dm_data <= dm_val(int'(o_dm_addr));
  end

  // UART model: done pulse three cycles after each start
  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_done <= 1'b0;
    if (o_tx_start) tx_timer <= 2;
    else if (tx_timer != 0) begin
      tx_timer <= tx_timer - 1;
      if (tx_timer == 1) model_done <= 1'b1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [7:0] eb;
    logic [6:0] ea;
    if (o_tx_start) begin
      if (exp_bytes.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_byte: actual=%0h expected=none", o_tx_data);
      end else begin
        eb = exp_bytes.pop_front();
        check("tx_byte", 64'(o_tx_data), 64'(eb));
      end
      if (tx_count < 300) byte_log[tx_count] = o_tx_data;
      tx_count++;
      if (strobe_pending) begin
        check("strobe_to_first_tx", 64'(cyc - strobe_cyc), 64'd2);
        strobe_pending = 1'b0;
      end
    end
    if (o_rb_read_enable || o_dm_read_enable) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: actual=%0h expected=none",
                 {o_dm_read_enable, o_rb_read_enable, o_rb_read_enable ? o_rb_addr : o_dm_addr});
      end else begin
        ea = exp_addr.pop_front();
        check("read_addr", 64'({o_dm_read_enable, o_rb_read_enable,
              o_rb_read_enable ? o_rb_addr : o_dm_addr}), 64'(ea));
      end
      if (o_rb_read_enable) rb_strobes++;
      if (o_dm_read_enable) dm_strobes++;
      strobe_pending = 1'b1;
      strobe_cyc = cyc;
    end
    if (o_done) done_count++;
  end

  task automatic clear_sb();
    exp_bytes.delete();
    exp_addr.delete();
    tx_count = 0;
    done_count = 0;
    rb_strobes = 0;
    dm_strobes = 0;
    strobe_pending = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int k = 0; k < 32; k++) begin
      push_word(rb_val(k));
      exp_addr.push_back({2'b01, 5'(k)});
    end
    for (int k = 0; k < 32; k++) begin
      push_word(dm_val(k));
      exp_addr.push_back({2'b10, 5'(k)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_count > 0) break;
    end
    if (i == 4000) check({name, "_timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_full(input string name);
    check({name, "_bytes"}, 64'(tx_count), 64'(TOTAL_BYTES));
    check({name, "_done_pulses"}, 64'(done_count), 64'd1);
    check({name, "_rb_strobes"}, 64'(rb_strobes), 64'd32);
    check({name, "_dm_strobes"}, 64'(dm_strobes), 64'd32);
    check({name, "_left_bytes"}, 64'(exp_bytes.size()), 64'd0);
    check({name, "_busy_after"}, 64'({o_busy, o_dm_du_flag}), 64'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_pc_value = 32'h00000040;
    #2 i_reset = 1'b0;
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_outputs", 64'({o_rb_addr, o_rb_enable, o_rb_read_enable, o_dm_addr, o_dm_enable,
          o_dm_read_enable, o_dm_du_flag, o_tx_data, o_tx_start, o_busy, o_done}), 64'd0);
    i_start = 1'b0;
    @(posedge clk); #1 i_reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_tx", 64'(tx_count), 64'd0);
    check("idle_no_busy", 64'(o_busy), 64'd0);

    // Full dump
    clear_sb();
    push_dump(32'h00000040);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 64'({o_busy, o_dm_du_flag}), 64'h3);
    wait_done("full");
    check_full("full");
    check("first_byte", 64'(byte_log[0]), 64'h40);
    check("byte_1", 64'(byte_log[1]), 64'h00);
    check("rb0_byte", 64'(byte_log[4]), 64'h00);
    check("rb1_byte", 64'(byte_log[8]), 64'h01);
    check("rb1_byte3", 64'(byte_log[11]), 64'h01);
    check("last_word", 64'({byte_log[256], byte_log[257], byte_log[258], byte_log[259]}),
          64'h1F0000A5);

    // Spurious done while idle
    @(posedge clk); #1 spurious_done = 1'b1;
    @(posedge clk); #1 spurious_done = 1'b0;
    clear_sb();
    repeat (5) @(negedge clk);
    check("idle_spurious_no_tx", 64'(tx_count), 64'd0);

    // Start ignored while busy
    clear_sb();
    push_dump(32'h00000040);
    pulse_start();
    for (int i = 0; i < 2000 && tx_count < 50; i++) @(negedge clk);
    check("reached_byte_50", 64'(tx_count >= 50), 64'd1);
    pulse_start();
    wait_done("busy_start");
    check_full("busy_start");

    // Spurious done during RB_CAP
    clear_sb();
    push_dump(32'h00000040);
    pulse_start();
    for (int i = 0; i < 200 && !o_rb_read_enable; i++) @(negedge clk);
    check("saw_rb_req", 64'(o_rb_read_enable), 64'd1);
    @(posedge clk); #1 spurious_done = 1'b1;
    @(posedge clk); #1 spurious_done = 1'b0;
    wait_done("spurious");
    check_full("spurious");

    // Abort during DM word 5
    clear_sb();
    push_dump(32'h00000040);
    pulse_start();
    for (int i = 0; i < 3000 && !(o_dm_read_enable && o_dm_addr == 5'd5); i++) @(negedge clk);
    check("saw_dm5_req", 64'({o_dm_read_enable, o_dm_addr}), 64'({1'b1, 5'd5}));
    repeat (6) @(posedge clk);
    #3 i_reset = 1'b0;
    exp_bytes.delete();
    exp_addr.delete();
    strobe_pending = 1'b0;
    #1;
    check("abort_async_outputs", 64'({o_rb_enable, o_dm_enable, o_dm_du_flag, o_tx_data,
          o_tx_start, o_busy, o_done}), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'd0);
    @(posedge clk); #1 i_reset = 1'b1;
    repeat (6) @(negedge clk);
    clear_sb();
    i_pc_value = 32'h0000BEEF;
    push_dump(32'h0000BEEF);
    pulse_start();
    wait_done("restart");
    check_full("restart");
    check("restart_pc", 64'({byte_log[0], byte_log[1], byte_log[2], byte_log[3]}), 64'hEFBE0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
